instr_sequencer: RTL and testbench

- Front-end controller for the uTPU datapath.
- Pulls instruction bytes from the RX FIFO and assembles 16-bit instructions, low byte first.
- Decodes each instruction and issues one command at a time to the buffer/PE/quantizer/ReLU datapath over a start/done handshake.
- Guards every command with a watchdog. Reports halt and error status.

---
 rtl/instr_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : uTPU front-end. Assembles 16-bit instructions from the RX FIFO
//               and issues one command at a time to the datapath under a
//               watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int INSTR_WIDTH     = 16,
    parameter int OPCODE_WIDTH    = 3,
    parameter int ADDRESS_SIZE    = 9,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       rx_empty,
    input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
    output logic                       rx_re,
    output logic                       op_start,
    output logic [OPCODE_WIDTH-1:0]    op_code,
    output logic [ADDRESS_SIZE-1:0]    op_addr,
    output logic [2:0]                 op_flags,
    input  logic                       op_done,
    output logic                       busy,
    output logic                       halted,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [COUNT_WIDTH-1:0]     instr_count
);

    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_FETCH = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_RUN   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_REQ      = 4'd1,
        ST_CAP      = 4'd2,
        ST_DECODE   = 4'd3,
        ST_EXT_DONE = 4'd4,
        ST_ISSUE    = 4'd5,
        ST_WAIT     = 4'd6,
        ST_HALTED   = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    state_t                      state_q;
    logic                        byte_cnt_q;
    logic                        ext_mode_q;
    logic [INSTR_WIDTH-1:0]      instr_q;
    logic [INSTR_WIDTH-1:0]      ext_q;
    logic [WD_WIDTH-1:0]         wd_q;
    logic [WD_WIDTH-1:0]         wd_d;
    logic                        op_start_q;
    logic [OPCODE_WIDTH-1:0]     op_code_q;
    logic [ADDRESS_SIZE-1:0]     op_addr_q;
    logic [2:0]                  op_flags_q;
    logic                        busy_q;
    logic                        halted_q;
    logic                        err_q;
    logic [1:0]                  err_code_q;
    logic [COUNT_WIDTH-1:0]      count_q;

    logic [OPCODE_WIDTH-1:0]     w_opcode;
    logic [2:0]                  w_flags;
    logic [ADDRESS_SIZE-1:0]     w_addr;
    logic                        unused_bits;

    assign w_opcode = instr_q[OPCODE_WIDTH-1:0];
    assign w_flags  = instr_q[5:3];
    assign w_addr   = instr_q[INSTR_WIDTH-1 -: ADDRESS_SIZE];
    assign wd_d     = wd_q + 1'b1;

    // Bit 6 of the instruction and the upper extended-word bits carry no meaning.
    assign unused_bits = &{1'b0, instr_q[6], ext_q[INSTR_WIDTH-1:ADDRESS_SIZE]};

    // Read strobe is combinational so it can never coincide with an empty FIFO.
    assign rx_re       = (state_q == ST_REQ) && !rx_empty;
    assign op_start    = op_start_q;
    assign op_code     = op_code_q;
    assign op_addr     = op_addr_q;
    assign op_flags    = op_flags_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign instr_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 1'b0;
            ext_mode_q <= 1'b0;
            instr_q    <= '0;
            ext_q      <= '0;
            wd_q       <= '0;
            op_start_q <= 1'b0;
            op_code_q  <= '0;
            op_addr_q  <= '0;
            op_flags_q <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            count_q    <= '0;
        end else begin
            op_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!rx_empty) begin
                        state_q <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    if (!byte_cnt_q) begin
                        if (ext_mode_q) begin
                            ext_q[FIFO_DATA_WIDTH-1:0] <= rx_data;
                        end else begin
                            instr_q[FIFO_DATA_WIDTH-1:0] <= rx_data;
                        end
                        byte_cnt_q <= 1'b1;
                        state_q    <= ST_REQ;
                    end else begin
                        if (ext_mode_q) begin
                            ext_q[INSTR_WIDTH-1:FIFO_DATA_WIDTH] <= rx_data;
                        end else begin
                            instr_q[INSTR_WIDTH-1:FIFO_DATA_WIDTH] <= rx_data;
                        end
                        byte_cnt_q <= 1'b0;
                        state_q    <= ext_mode_q ? ST_EXT_DONE : ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_opcode)
                        OP_NOP: begin
                            state_q <= ST_REQ;
                        end
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_HALTED;
                        end
                        OP_STORE, OP_FETCH, OP_RUN, OP_LOAD: begin
                            // STORE with flag bit4 takes its address from a second word.
                            if ((w_opcode == OP_STORE) && w_flags[1]) begin
                                ext_mode_q <= 1'b1;
                                state_q    <= ST_REQ;
                            end else begin
                                op_code_q  <= w_opcode;
                                op_addr_q  <= w_addr;
                                op_flags_q <= w_flags;
                                op_start_q <= 1'b1;
                                state_q    <= ST_ISSUE;
                            end
                        end
                        default: begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                            busy_q     <= 1'b0;
                            state_q    <= ST_ERROR;
                        end
                    endcase
                end
                ST_EXT_DONE: begin
                    op_code_q  <= w_opcode;
                    op_flags_q <= w_flags;
                    op_addr_q  <= ext_q[ADDRESS_SIZE-1:0];
                    ext_mode_q <= 1'b0;
                    op_start_q <= 1'b1;
                    state_q    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over the watchdog on the limit cycle.
                    if (op_done) begin
                        count_q <= count_q + 1'b1;
                        state_q <= ST_REQ;
                    end else if (wd_d == WD_LIMIT) begin
                        wd_q       <= wd_d;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        busy_q     <= 1'b0;
                        state_q    <= ST_ERROR;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        halted_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer: FIFO model, datapath
//               responder and command scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int T = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rx_empty;
    logic [7:0]  rx_data;
    logic        rx_re;
    logic        op_start;
    logic [2:0]  op_code;
    logic [8:0]  op_addr;
    logic [2:0]  op_flags;
    logic        op_done;
    logic        busy;
    logic        halted;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] instr_count;

    instr_sequencer #(
        .FIFO_DATA_WIDTH(8),
        .INSTR_WIDTH    (16),
        .OPCODE_WIDTH   (3),
        .ADDRESS_SIZE   (9),
        .TIMEOUT_CYCLES (T),
        .COUNT_WIDTH    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rx_re      (rx_re),
        .op_start   (op_start),
        .op_code    (op_code),
        .op_addr    (op_addr),
        .op_flags   (op_flags),
        .op_done    (op_done),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .err_code   (err_code),
        .instr_count(instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] code;
        logic [8:0] addr;
        logic [2:0] flags;
    } cmd_t;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        bit          ext;
        int          dly;
        cmd_t        cmd;
    } vec_t;

    cmd_t        exp_q[$];
    logic [7:0]  fifo[$];
    vec_t        vt[6];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mdl_count = 0;
    int          resp_dly = -1;
    int          resp_timer = -1;
    int          last_start_cyc = 0;
    int          start_cyc = 0;
    int          viol_rx = 0;
    int          viol_pulse = 0;
    int          viol_hold = 0;
    bit          in_wait = 0;
    bit          prev_start = 0;
    bit          hold_empty = 0;
    bit          rand_empty = 0;
    logic [14:0] cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic upd_empty();
        rx_empty = hold_empty || (fifo.size() == 0);
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo.push_back(w[7:0]);
        fifo.push_back(w[15:8]);
        upd_empty();
    endtask

    // One clock: observe at the falling edge, drive just after the rising edge.
    task automatic tick();
        bit   pend;
        cmd_t e;
        @(negedge clk);
        cyc++;
        if (rx_re && rx_empty) viol_rx++;
        pend = rx_re && !rx_empty;
        if (op_start) begin
            if (prev_start) viol_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_op_start", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("op_cmd", {op_code, op_addr, op_flags}, e);
            end
            cur            = {op_code, op_addr, op_flags};
            last_start_cyc = cyc;
            in_wait        = 1;
            resp_timer     = resp_dly;
        end else if (in_wait && ({op_code, op_addr, op_flags} != cur)) begin
            viol_hold++;
        end
        prev_start = op_start;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op_done = 1'b0;
        if (pend && fifo.size() > 0) rx_data = fifo.pop_front();
        if (in_wait && resp_timer >= 0) begin
            if (resp_timer == 0) begin
                op_done    = 1'b1;
                in_wait    = 0;
                mdl_count++;
                resp_timer = -1;
            end else begin
                resp_timer--;
            end
        end
        if (rand_empty) hold_empty = ($urandom_range(0, 1) == 1);
        upd_empty();
    endtask

    task automatic wait_done(input string name, input int bound);
        int c0;
        c0 = mdl_count;
        for (int i = 0; i < bound && mdl_count == c0; i++) tick();
        check(name, mdl_count, c0 + 1);
        tick();
        check({name, "_count"}, instr_count, mdl_count & 16'hFFFF);
    endtask

    task automatic apply_vec(input vec_t v, input string name, input bit do_start);
        push_word(v.w0);
        if (v.ext) push_word(v.w1);
        exp_q.push_back(v.cmd);
        resp_dly = v.dly;
        if (do_start) begin
            start     = 1'b1;
            start_cyc = cyc + 1;
        end
        wait_done(name, 3000);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(input string name);
        #2 rst = 1'b1;
        #1;
        check(name, {rx_re, op_start, op_code, op_addr, op_flags, busy, halted,
                     err, err_code, instr_count}, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_q.delete();
        fifo.delete();
        in_wait    = 0;
        resp_timer = -1;
        resp_dly   = -1;
        mdl_count  = 0;
        prev_start = 0;
        op_done    = 1'b0;
        start      = 1'b0;
        hold_empty = 0;
        upd_empty();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        vt[0] = '{16'h0182, 16'h0000, 1'b0, 5, '{3'd2, 9'h003, 3'b000}};
        vt[1] = '{16'h0010, 16'h01FF, 1'b1, 2, '{3'd0, 9'h1FF, 3'b010}};
        vt[2] = '{16'hAAA9, 16'h0000, 1'b0, 0, '{3'd1, 9'h155, 3'b101}};
        vt[3] = '{16'hFFFB, 16'h0000, 1'b0, 3, '{3'd3, 9'h1FF, 3'b111}};
        vt[4] = '{16'h0528, 16'h0000, 1'b0, 1, '{3'd0, 9'h00A, 3'b101}};
        vt[5] = '{16'h0038, 16'hFE00, 1'b1, 4, '{3'd0, 9'h000, 3'b111}};

        rst = 1'b1; start = 1'b0; op_done = 1'b0; rx_data = 8'h00;
        upd_empty();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {rx_re, op_start, op_code, op_addr, op_flags, busy,
                                halted, err, err_code, instr_count}, 0);
        rst = 1'b0;
        tick();
        check("idle_not_busy", busy, 0);

        // Table-driven commands; the first also checks fetch-to-issue latency.
        for (int i = 0; i < 6; i++) begin
            apply_vec(vt[i], $sformatf("vec%0d", i), i == 0);
            if (i == 0) check("issue_latency", last_start_cyc - start_cyc, 6);
        end
        check("busy_in_req", busy, 1);

        // NOP then HALT, then resume with start.
        push_word(16'h0005);
        push_word(16'h0004);
        for (int i = 0; i < 60 && !halted; i++) tick();
        check("halted", halted, 1);
        check("halt_not_busy", busy, 0);
        check("halt_count", instr_count, mdl_count & 16'hFFFF);
        apply_vec(vt[0], "resume", 1);
        start = 1'b1;
        apply_vec(vt[2], "start_while_busy", 0);

        // Partial word held with an empty FIFO.
        fifo.push_back(8'h82);
        upd_empty();
        exp_q.push_back(vt[0].cmd);
        resp_dly = 2;
        repeat (40) tick();
        check("partial_pending", exp_q.size(), 1);
        check("partial_busy", busy, 1);
        check("partial_no_err", err, 0);
        fifo.push_back(8'h01);
        upd_empty();
        wait_done("partial_done", 100);

        // Random FIFO-empty toggling between bytes.
        rand_empty = 1;
        for (int i = 0; i < 6; i++) apply_vec(vt[i], $sformatf("rnd%0d", i), 0);
        rand_empty = 0;
        hold_empty = 0;
        upd_empty();

        // op_done on the watchdog limit cycle wins.
        apply_vec('{16'h0083, 16'h0000, 1'b0, T - 2, '{3'd3, 9'h001, 3'b000}}, "limit_done", 0);
        check("limit_no_err", err, 0);

        // Watchdog timeout with op_done withheld.
        push_word(16'h0083);
        exp_q.push_back('{3'd3, 9'h001, 3'b000});
        resp_dly = -1;
        for (int i = 0; i < T + 100 && !err; i++) tick();
        check("timeout_code", err_code, 2'b10);
        check("timeout_latency", cyc + 1 - last_start_cyc, T);
        check("timeout_not_busy", busy, 0);
        in_wait = 0;
        push_word(16'h0182);
        start = 1'b1;
        repeat (20) tick();
        check("err_start_ignored", {err, err_code, busy}, {1'b1, 2'b10, 1'b0});
        check("err_no_fetch", fifo.size(), 2);
        do_reset("rst_clears_timeout");

        // Illegal opcode.
        push_word(16'h0006);
        start = 1'b1;
        for (int i = 0; i < 60 && !err; i++) tick();
        check("illegal_err", {err, err_code, busy}, {1'b1, 2'b01, 1'b0});
        push_word(16'h0182);
        start = 1'b1;
        repeat (20) tick();
        check("illegal_start_ignored", {err, err_code}, {1'b1, 2'b01});
        check("illegal_no_fetch", fifo.size(), 2);
        do_reset("rst_clears_illegal");

        // Partial word discarded by reset, then reset during WAIT.
        fifo.push_back(8'h82);
        upd_empty();
        start = 1'b1;
        repeat (10) tick();
        do_reset("rst_partial");
        push_word(16'h0182);
        exp_q.push_back(vt[0].cmd);
        resp_dly = -1;
        start = 1'b1;
        for (int i = 0; i < 50 && !in_wait; i++) tick();
        check("discard_issued", in_wait, 1);
        repeat (5) tick();
        do_reset("rst_in_wait");
        apply_vec(vt[3], "post_reset", 1);

        check("rx_re_vs_empty", viol_rx, 0);
        check("op_start_single", viol_pulse, 0);
        check("op_fields_held", viol_hold, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
